// File: rtl/scan_seq8_pkg.sv
// Shared types and constants for the scan_seq8 channel sequencer.
// The BLANK state is only entered when SCAN_SEQ8_BLANK_EN is defined.
package scan_seq8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int DIV_W_DEFAULT = 16;
  localparam int NUM_CH        = 8;

endpackage

// File: rtl/scan_next8.sv
// Combinational next-set-bit finder: returns the lowest set bit of mask above cur,
// or the lowest set bit overall with wrap = 1 when none lies above cur.
module scan_next8
  import scan_seq8_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [2:0]        cur,
  output logic [2:0]        nxt,
  output logic              wrap
);

  // Descending scans so the last hit is the lowest qualifying bit.
  always_comb begin
    nxt  = '0;
    wrap = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) nxt = 3'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt  = 3'(i);
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_seq8.sv
// Decoder scan sequencer: dwells on each enabled channel for div+1 cycles.
// Define SCAN_SEQ8_BLANK_EN to insert a one-cycle ena-low BLANK before every channel advance.
module scan_seq8
  import scan_seq8_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic [NUM_CH-1:0] mask,
  input  logic [DIV_W-1:0]  div,
  output logic [2:0]        a,
  output logic              ena,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [2:0]        a_q, a_d;
  logic              ena_q, ena_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              cont_q, cont_d;

  logic [NUM_CH-1:0] sel_mask;
  logic [2:0]        sel_cur;
  logic [2:0]        nxt;
  logic              wrap;

  // In IDLE, searching above channel 7 always wraps, yielding the lowest set bit for a start.
  assign sel_mask = (state_q == IDLE) ? mask : mask_q;
  assign sel_cur  = (state_q == IDLE) ? 3'd7 : a_q;

  scan_next8 u_next (
    .mask (sel_mask),
    .cur  (sel_cur),
    .nxt  (nxt),
    .wrap (wrap)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ena_d   = ena_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    unique case (state_q)
      IDLE: begin
        ena_d = 1'b0;
        if (start && !stop && (mask != '0)) begin
          state_d = DWELL;
          mask_d  = mask;
          div_d   = div;
          cont_d  = cont;
          a_d     = nxt;
          ena_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
          ena_d   = 1'b0;
        end else if (cnt_q == div_q) begin
          cnt_d = '0;
          if (wrap && !cont_q) begin
            state_d = IDLE;
            ena_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            a_d = nxt;
`ifdef SCAN_SEQ8_BLANK_EN
            state_d = BLANK;
            ena_d   = 1'b0;
`else
            ena_d   = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SCAN_SEQ8_BLANK_EN
      BLANK: begin
        if (stop) begin
          state_d = IDLE;
          ena_d   = 1'b0;
        end else begin
          state_d = DWELL;
          ena_d   = 1'b1;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        ena_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  assign a    = a_q;
  assign ena  = ena_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule
